mux_scan_n_to_1: RTL and testbench

MUX_SCAN_N_TO_1 -- requirements
Module: mux_scan_n_to_1

---
 rtl/mux_scan_n_to_1.sv | 96 +++++++++
 tb/tb_mux_scan_n_to_1.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n_to_1.sv
// rtl/mux_scan_n_to_1.sv - registered N:1 mux with manual select and timed auto-scan
module mux_scan_n_to_1 #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int DWELL = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        mode,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] sel,
    input  logic [CH*WIDTH-1:0]         x,
    output logic [WIDTH-1:0]            y,
    output logic                        y_valid,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cur_sel,
    output logic                        ch_change
);

    localparam int SEL_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    localparam int NSLOT  = 2 ** SEL_W;

    localparam logic [SEL_W:0]    CH_L     = CH[SEL_W:0];
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(CH - 1);
    localparam logic [DCNT_W-1:0] DLAST    = DCNT_W'(DWELL - 1);

    logic [SEL_W-1:0]  r_cur_sel;
    logic [DCNT_W-1:0] r_dcnt;
    logic [WIDTH-1:0]  r_y;
    logic              r_y_valid;
    logic              r_ch_change;

    logic [SEL_W-1:0]  w_nxt_sel;
    logic [DCNT_W-1:0] w_nxt_dcnt;
    logic [WIDTH-1:0]  w_nxt_y;
    logic              w_nxt_valid;
    logic              w_sel_ok;
    logic [WIDTH-1:0]  w_ch [NSLOT];

    // Slots beyond CH read as zero so a non-power-of-2 CH never indexes past x.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        if (k < CH) begin : g_used
            assign w_ch[k] = x[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_ch[k] = '0;
        end
    end

    assign w_sel_ok = ({1'b0, sel} < CH_L);

    always_comb begin
        w_nxt_sel   = r_cur_sel;
        w_nxt_dcnt  = r_dcnt;
        w_nxt_valid = 1'b0;
        if (en) begin
            if (!mode) begin
                w_nxt_dcnt = '0;
                if (w_sel_ok) begin
                    w_nxt_sel   = sel;
                    w_nxt_valid = 1'b1;
                end
            end else begin
                w_nxt_valid = 1'b1;
                if (r_dcnt >= DLAST) begin
                    w_nxt_dcnt = '0;
                    w_nxt_sel  = (r_cur_sel == SEL_LAST) ? '0 : r_cur_sel + SEL_W'(1);
                end else begin
                    w_nxt_dcnt = r_dcnt + DCNT_W'(1);
                end
            end
        end
        w_nxt_y = w_nxt_valid ? w_ch[w_nxt_sel] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_sel   <= '0;
            r_dcnt      <= '0;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_ch_change <= 1'b0;
        end else begin
            r_cur_sel   <= w_nxt_sel;
            r_dcnt      <= w_nxt_dcnt;
            r_y         <= w_nxt_y;
            r_y_valid   <= w_nxt_valid;
            r_ch_change <= (w_nxt_sel != r_cur_sel);
        end
    end

    assign y         = r_y;
    assign y_valid   = r_y_valid;
    assign cur_sel   = r_cur_sel;
    assign ch_change = r_ch_change;

endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// tb/tb_mux_scan_n_to_1.sv - bench for mux_scan_n_to_1 (CH=4 and CH=3 instances, DWELL=3)
module tb_mux_scan_n_to_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] x;

    logic [7:0]  ya, yb;
    logic        va, vb;
    logic [1:0]  ca, cb;
    logic        ga, gb;

    always #5 clk = ~clk;

    mux_scan_n_to_1 #(.WIDTH(8), .CH(4), .DWELL(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .x(x),
        .y(ya), .y_valid(va), .cur_sel(ca), .ch_change(ga)
    );

    mux_scan_n_to_1 #(.WIDTH(8), .CH(3), .DWELL(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .x(x[23:0]),
        .y(yb), .y_valid(vb), .cur_sel(cb), .ch_change(gb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: track the channel and how many enabled scan cycles it has consumed.
    typedef struct {
        int sel;
        int spent;
        int y;
        bit valid;
        bit chg;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, int ch, int dwell, bit en_i, bit mode_i,
                                  int sel_i, logic [31:0] xv);
        mdl_t n;
        n       = m;
        n.y     = 0;
        n.valid = 1'b0;
        if (en_i) begin
            if (!mode_i) begin
                n.spent = 0;
                if (sel_i < ch) begin
                    n.sel   = sel_i;
                    n.valid = 1'b1;
                end
            end else begin
                n.spent = m.spent + 1;
                if (n.spent >= dwell) begin
                    n.spent = 0;
                    n.sel   = (m.sel + 1) % ch;
                end
                n.valid = 1'b1;
            end
        end
        if (n.valid) n.y = int'((xv >> (8 * n.sel)) & 32'hff);
        n.chg = (n.sel != m.sel);
        return n;
    endfunction

    task automatic model_reset();
        ma = '{default: 0};
        mb = '{default: 0};
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a.y"},   32'(ya), 32'(ma.y));
        check({tag, ".a.v"},   32'(va), 32'(ma.valid));
        check({tag, ".a.sel"}, 32'(ca), 32'(ma.sel));
        check({tag, ".a.chg"}, 32'(ga), 32'(ma.chg));
        check({tag, ".b.y"},   32'(yb), 32'(mb.y));
        check({tag, ".b.v"},   32'(vb), 32'(mb.valid));
        check({tag, ".b.sel"}, 32'(cb), 32'(mb.sel));
        check({tag, ".b.chg"}, 32'(gb), 32'(mb.chg));
    endtask

    task automatic tick(input string tag);
        ma = step(ma, 4, 3, en, mode, int'(sel), x);
        mb = step(mb, 3, 3, en, mode, int'(sel), {8'h00, x[23:0]});
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    logic [7:0] man_y [4];
    int         scan_seq [12];
    int         prev;
    int         guard;

    initial begin
        man_y    = '{8'h11, 8'h22, 8'h33, 8'h44};
        scan_seq = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = 2'd0;
        x     = 32'h44332211;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // manual sweep; instance b sees sel=3 as out of range
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick("manual");
            check("manual.y", 32'(ya), 32'(man_y[s]));
            check("manual.chg", 32'(ga), (s > 0) ? 32'd1 : 32'd0);
        end
        check("oor.b.v", 32'(vb), 32'd0);
        check("oor.b.sel", 32'(cb), 32'd2);
        check("oor.b.chg", 32'(gb), 32'd0);

        // scan wrap from reset
        #2 rst_n = 1'b0;
        #1 model_reset();
        rst_n = 1'b1;
        mode  = 1'b1;
        prev  = 0;
        for (int i = 0; i < 12; i++) begin
            tick("scan");
            check("scan.seq", 32'(ca), 32'(scan_seq[i]));
            check("scan.chg", 32'(ga), (scan_seq[i] != prev) ? 32'd1 : 32'd0);
            prev = scan_seq[i];
        end

        // enable gating on channel 2 after one dwell step
        guard = 0;
        while (!(ma.sel == 2 && ma.spent == 1) && guard < 20) begin
            tick("toch2");
            guard++;
        end
        check("gate.reach", (guard < 20) ? 32'd1 : 32'd0, 32'd1);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick("gate.off");
            check("gate.y", 32'(ya), 32'd0);
            check("gate.v", 32'(va), 32'd0);
            check("gate.sel", 32'(ca), 32'd2);
        end
        en = 1'b1;
        tick("gate.on1");
        check("gate.on1.sel", 32'(ca), 32'd2);
        tick("gate.on2");
        check("gate.on2.sel", 32'(ca), 32'd3);

        // mode switching
        mode = 1'b0;
        sel  = 2'd2;
        tick("sw.man");
        mode = 1'b1;
        tick("sw.scan1");
        check("sw.scan1.sel", 32'(ca), 32'd2);
        tick("sw.scan2");
        check("sw.scan2.sel", 32'(ca), 32'd2);
        tick("sw.scan3");
        check("sw.scan3.sel", 32'(ca), 32'd3);
        mode = 1'b0;
        sel  = 2'd0;
        tick("sw.back");
        check("sw.back.sel", 32'(ca), 32'd0);
        check("sw.back.chg", 32'(ga), 32'd1);

        // asynchronous reset mid-scan on channel 3
        mode  = 1'b1;
        guard = 0;
        while (ma.sel != 3 && guard < 20) begin
            tick("toch3");
            guard++;
        end
        check("arst.reach", (guard < 20) ? 32'd1 : 32'd0, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst.low");
        check("arst.y", 32'(ya), 32'd0);
        check("arst.sel", 32'(ca), 32'd0);
        rst_n = 1'b1;
        tick("arst.r1");
        check("arst.r1.sel", 32'(ca), 32'd0);
        tick("arst.r2");
        check("arst.r2.sel", 32'(ca), 32'd0);
        tick("arst.r3");
        check("arst.r3.sel", 32'(ca), 32'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 7) != 0);
            mode = ($urandom_range(0, 2) != 0);
            sel  = 2'($urandom_range(0, 3));
            x    = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd.arst");
                rst_n = 1'b1;
            end
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
